// File: rtl/div_fp64_iter.sv
// Iterative IEEE-754 binary64 divider (DAZ/FTZ), one quotient bit per cycle.
// Latency: result and flags qualified by a one-cycle valid, 58 cycles after operand accept.
// Backpressure: none; en is ignored while busy and during the valid cycle.
//
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   en, rm, src1, src2  : operand strobe, rounding mode, dividend, divisor
//   busy                : operation in flight (DIV/ROUND)
//   valid               : one-cycle pulse qualifying result/nv/dz/of
//   result, nv, dz, of  : quotient and invalid / divide-by-zero / overflow flags
module div_fp64_iter #(
   parameter int LATENCY = 58
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        en,
   input  logic [2:0]  rm,
   input  logic [63:0] src1,
   input  logic [63:0] src2,
   output logic        busy,
   output logic        valid,
   output logic [63:0] result,
   output logic        nv,
   output logic        dz,
   output logic        of
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DIV   = 2'd1;
   localparam logic [1:0] ROUND = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [2:0] RM_RTE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   // Accept and ROUND each take one edge; the rest of the latency is quotient bits.
   localparam int         DIV_CYCLES = LATENCY - 2;
   localparam logic [5:0] DIV_LAST   = 6'(DIV_CYCLES - 1);

   localparam logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000;

   logic [1:0]  state;
   logic [5:0]  cnt;
   logic [2:0]  rm_q;
   logic [63:0] a_q;
   logic [63:0] b_q;
   logic [53:0] rem;
   logic [55:0] quo;

   // Restoring division step
   logic [53:0] divisor;
   logic        q_bit;
   logic [53:0] diff;
   logic [53:0] rem_nxt;

   assign divisor = {2'b01, b_q[51:0]};
   assign q_bit   = (rem >= divisor);
   assign diff    = q_bit ? (rem - divisor) : rem;
   // diff < divisor < 2^53, so the shift never loses a set bit
   assign rem_nxt = diff << 1;

   // Operand classification (subnormals are treated as zero)
   logic a_exp_max, b_exp_max, a_frac_nz, b_frac_nz;
   logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;

   assign a_exp_max = &a_q[62:52];
   assign b_exp_max = &b_q[62:52];
   assign a_frac_nz = |a_q[51:0];
   assign b_frac_nz = |b_q[51:0];
   assign a_nan     = a_exp_max & a_frac_nz;
   assign b_nan     = b_exp_max & b_frac_nz;
   assign a_snan    = a_nan & ~a_q[51];
   assign b_snan    = b_nan & ~b_q[51];
   assign a_inf     = a_exp_max & ~a_frac_nz;
   assign b_inf     = b_exp_max & ~b_frac_nz;
   assign a_zero    = ~|a_q[62:52];
   assign b_zero    = ~|b_q[62:52];

   // Normalise / round / pack
   logic               sign;
   logic signed [12:0] exp_raw, exp_n, exp_f;
   logic [52:0]        mant;
   logic               g, r, s, inexact, inc;
   logic [53:0]        mant_r;
   logic [51:0]        frac;
   logic [63:0]        zero_val, inf_val, max_val;
   logic [63:0]        res_c;
   logic               nv_c, dz_c, of_c;

   always_comb begin
      sign     = a_q[63] ^ b_q[63];
      zero_val = {sign, 63'd0};
      inf_val  = {sign, 11'h7FF, 52'd0};
      max_val  = {sign, 11'h7FE, {52{1'b1}}};
      exp_raw  = $signed({2'b00, a_q[62:52]}) - $signed({2'b00, b_q[62:52]}) + 13'sd1023;

      // Quotient MSB is the integer bit; if clear, the value is in [0.5,1).
      if (quo[55]) begin
         mant  = quo[55:3];
         g     = quo[2];
         r     = quo[1];
         s     = quo[0] | (|rem);
         exp_n = exp_raw;
      end else begin
         mant  = quo[54:2];
         g     = quo[1];
         r     = quo[0];
         s     = |rem;
         exp_n = exp_raw - 13'sd1;
      end
      inexact = g | r | s;

      case (rm_q)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign & inexact;
         RM_RUP:  inc = ~sign & inexact;
         RM_RMM:  inc = g;
         default: inc = g & (r | s | mant[0]);
      endcase

      mant_r = {1'b0, mant} + 54'(inc);
      if (mant_r[53]) begin
         frac  = mant_r[52:1];
         exp_f = exp_n + 13'sd1;
      end else begin
         frac  = mant_r[51:0];
         exp_f = exp_n;
      end

      res_c = {sign, exp_f[10:0], frac};
      nv_c  = 1'b0;
      dz_c  = 1'b0;
      of_c  = 1'b0;

      if (a_nan | b_nan) begin
         res_c = CANON_NAN;
         nv_c  = a_snan | b_snan;
      end else if ((a_inf & b_inf) | (a_zero & b_zero)) begin
         res_c = CANON_NAN;
         nv_c  = 1'b1;
      end else if (a_inf) begin
         res_c = inf_val;
      end else if (b_inf | a_zero) begin
         res_c = zero_val;
      end else if (b_zero) begin
         res_c = inf_val;
         dz_c  = 1'b1;
      end else if (exp_f >= 13'sd2047) begin
         of_c = 1'b1;
         case (rm_q)
            RM_RTZ:  res_c = max_val;
            RM_RDN:  res_c = sign ? inf_val : max_val;
            RM_RUP:  res_c = sign ? max_val : inf_val;
            default: res_c = inf_val;
         endcase
      end else if (exp_f <= 13'sd0) begin
         res_c = zero_val;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         rm_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         rem    <= '0;
         quo    <= '0;
         result <= '0;
         nv     <= 1'b0;
         dz     <= 1'b0;
         of     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  rm_q  <= rm;
                  a_q   <= src1;
                  b_q   <= src2;
                  rem   <= {2'b01, src1[51:0]};
                  quo   <= '0;
                  cnt   <= '0;
                  state <= DIV;
               end
            end
            DIV: begin
               rem <= rem_nxt;
               quo <= {quo[54:0], q_bit};
               cnt <= cnt + 6'd1;
               if (cnt == DIV_LAST) state <= ROUND;
            end
            ROUND: begin
               result <= res_c;
               nv     <= nv_c;
               dz     <= dz_c;
               of     <= of_c;
               state  <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy  = (state == DIV) || (state == ROUND);
   assign valid = (state == DONE);

endmodule

// File: tb/tb_div_fp64_iter.sv
// Bench for div_fp64_iter: directed vector table, hand-written timing/reset
// sequences, and random operands against an exact-integer reference model.
module tb_div_fp64_iter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic [2:0]  rm = 3'd0;
   logic [63:0] src1 = 64'd0;
   logic [63:0] src2 = 64'd0;
   logic        busy, valid, nv, dz, of;
   logic [63:0] result;

   int checks = 0;
   int failures = 0;

   div_fp64_iter #(.LATENCY(58)) dut (
      .clock(clock), .reset(reset), .en(en), .rm(rm), .src1(src1), .src2(src2),
      .busy(busy), .valid(valid), .result(result), .nv(nv), .dz(dz), .of(of)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [2:0]  rm;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      logic [2:0]  fl;   // {nv, dz, of}
   } vec_t;

   typedef struct {
      logic [63:0] res;
      logic [2:0]  fl;
   } ref_t;

   localparam int NVEC = 20;
   vec_t tbl [NVEC];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Exact reference: long integer quotient with full remainder, rounded
   // by comparing the discarded part against one half ulp.
   function automatic ref_t ref_div(input logic [2:0] m, input logic [63:0] a, input logic [63:0] b);
      ref_t o;
      logic sign, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
      logic [116:0] num, den, q, rm_v, d, half, mask;
      logic [53:0] keep;
      logic above, tie, inexact, up;
      logic [63:0] inf_v, max_v;
      int e, sh;
      o.res = 64'd0;
      o.fl  = 3'b000;
      sign   = a[63] ^ b[63];
      a_nan  = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
      b_nan  = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
      a_snan = a_nan && !a[51];
      b_snan = b_nan && !b[51];
      a_inf  = (a[62:52] == 11'h7FF) && (a[51:0] == 0);
      b_inf  = (b[62:52] == 11'h7FF) && (b[51:0] == 0);
      a_zero = (a[62:52] == 0);
      b_zero = (b[62:52] == 0);
      inf_v  = {sign, 11'h7FF, 52'd0};
      max_v  = {sign, 11'h7FE, {52{1'b1}}};
      if (a_nan || b_nan) begin
         o.res = 64'h7FF8_0000_0000_0000;
         o.fl  = {a_snan || b_snan, 2'b00};
      end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
         o.res = 64'h7FF8_0000_0000_0000;
         o.fl  = 3'b100;
      end else if (a_inf) begin
         o.res = inf_v;
      end else if (b_inf || a_zero) begin
         o.res = {sign, 63'd0};
      end else if (b_zero) begin
         o.res = inf_v;
         o.fl  = 3'b010;
      end else begin
         num  = {1'b1, a[51:0], 64'd0};
         den  = {64'd0, 1'b1, b[51:0]};
         q    = num / den;
         rm_v = num % den;
         e    = int'(a[62:52]) - int'(b[62:52]) + 1023;
         if (q[64]) sh = 12;
         else begin
            sh = 11;
            e  = e - 1;
         end
         keep    = 54'(q >> sh);
         mask    = (117'd1 << sh) - 117'd1;
         d       = q & mask;
         half    = 117'd1 << (sh - 1);
         above   = (d > half) || ((d == half) && (rm_v != 0));
         tie     = (d == half) && (rm_v == 0);
         inexact = (d != 0) || (rm_v != 0);
         case (m)
            3'd1:    up = 1'b0;
            3'd2:    up = inexact && sign;
            3'd3:    up = inexact && !sign;
            3'd4:    up = (d >= half);
            default: up = above || (tie && keep[0]);
         endcase
         keep = keep + 54'(up);
         if (keep[53]) begin
            keep = keep >> 1;
            e    = e + 1;
         end
         if (e >= 2047) begin
            o.fl = 3'b001;
            case (m)
               3'd1:    o.res = max_v;
               3'd2:    o.res = sign ? inf_v : max_v;
               3'd3:    o.res = sign ? max_v : inf_v;
               default: o.res = inf_v;
            endcase
         end else if (e <= 0) begin
            o.res = {sign, 63'd0};
         end else begin
            o.res = {sign, e[10:0], keep[51:0]};
         end
      end
      return o;
   endfunction

   function automatic logic [63:0] rnd_fp();
      logic [63:0] v;
      int c;
      v = {$urandom, $urandom};
      c = $urandom_range(0, 19);
      if (c == 0)      v[62:0] = 63'd0;
      else if (c == 1) v[62:0] = {11'h7FF, 52'd0};
      else if (c == 2) begin
         v[62:52] = 11'h7FF;
         if (v[51:0] == 0) v[0] = 1'b1;
      end
      else if (c == 3) v[62:52] = 11'd0;
      else if (c <= 7) v[62:52] = 11'($urandom_range(1, 2046));
      else             v[62:52] = 11'($urandom_range(1000, 1046));
      return v;
   endfunction

   // Starts at a negedge with the DUT idle. At negedge k after the accept
   // edge, the sampled values are those seen by edge T+k. Optionally pulses
   // en (with other operands) at T+intr. Returns at the negedge after the valid cycle.
   task automatic do_op(input logic [2:0] m, input logic [63:0] a, input logic [63:0] b,
                        input int intr, output logic [63:0] r, output logic [2:0] fl,
                        output int lat, output logic shape_ok);
      rm = m; src1 = a; src2 = b; en = 1'b1;
      @(negedge clock);
      en = 1'b0;
      lat = 1;
      shape_ok = 1'b1;
      while (!valid && lat < 200) begin
         if (!busy) shape_ok = 1'b0;
         en = (lat == intr);
         if (lat == intr) begin
            src1 = 64'h3FF0_0000_0000_0000;
            src2 = 64'h4008_0000_0000_0000;
            rm   = 3'd3;
         end
         @(negedge clock);
         lat++;
      end
      en = 1'b0;
      r  = result;
      fl = {nv, dz, of};
      if (busy) shape_ok = 1'b0;
      @(negedge clock);
      if (valid) shape_ok = 1'b0;
   endtask

   initial begin
      logic [63:0] r;
      logic [2:0]  fl;
      int          lat, nvalid;
      logic        shp;
      ref_t        exp_r;
      logic [2:0]  m;
      logic [63:0] a, b;

      tbl[0]  = '{"div6_2",       3'd0, 64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, 3'b000};
      tbl[1]  = '{"third_rte",    3'd0, 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 3'b000};
      tbl[2]  = '{"third_rup",    3'd3, 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555556, 3'b000};
      tbl[3]  = '{"third_rtz",    3'd1, 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 3'b000};
      tbl[4]  = '{"nthird_rdn",   3'd2, 64'hBFF0000000000000, 64'h4008000000000000, 64'hBFD5555555555556, 3'b000};
      tbl[5]  = '{"one_by_zero",  3'd0, 64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 3'b010};
      tbl[6]  = '{"zero_by_zero", 3'd0, 64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 3'b100};
      tbl[7]  = '{"inf_by_inf",   3'd0, 64'h7FF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 3'b100};
      tbl[8]  = '{"ovf_rte",      3'd0, 64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 64'h7FF0000000000000, 3'b001};
      tbl[9]  = '{"ovf_rtz",      3'd1, 64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 64'h7FEFFFFFFFFFFFFF, 3'b001};
      tbl[10] = '{"ovf_rdn_neg",  3'd2, 64'hFFEFFFFFFFFFFFFF, 64'h3FE0000000000000, 64'hFFF0000000000000, 3'b001};
      tbl[11] = '{"ovf_rup_neg",  3'd3, 64'hFFEFFFFFFFFFFFFF, 64'h3FE0000000000000, 64'hFFEFFFFFFFFFFFFF, 3'b001};
      tbl[12] = '{"snan_in",      3'd0, 64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 3'b100};
      tbl[13] = '{"qnan_in",      3'd0, 64'h3FF0000000000000, 64'hFFF8000000000001, 64'h7FF8000000000000, 3'b000};
      tbl[14] = '{"daz_sub",      3'd0, 64'h0000000000000001, 64'hBFF0000000000000, 64'h8000000000000000, 3'b000};
      tbl[15] = '{"fin_by_inf",   3'd0, 64'h3FF0000000000000, 64'h7FF0000000000000, 64'h0000000000000000, 3'b000};
      tbl[16] = '{"inf_by_neg",   3'd0, 64'h7FF0000000000000, 64'hC000000000000000, 64'hFFF0000000000000, 3'b000};
      tbl[17] = '{"ftz_min",      3'd0, 64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, 3'b000};
      tbl[18] = '{"nzero_by_fin", 3'd0, 64'h8000000000000000, 64'h4000000000000000, 64'h8000000000000000, 3'b000};
      tbl[19] = '{"ovf_rup_pos",  3'd3, 64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 64'h7FF0000000000000, 3'b001};

      repeat (3) @(negedge clock);
      chk("reset_ctrl", {59'd0, busy, valid, nv, dz, of}, 64'd0);
      chk("reset_result", result, 64'd0);

      // First op is presented on the same negedge reset is released.
      reset = 1'b0;
      for (int i = 0; i < NVEC; i++) begin
         do_op(tbl[i].rm, tbl[i].a, tbl[i].b, 0, r, fl, lat, shp);
         chk({tbl[i].name, "_res"}, r, tbl[i].exp);
         chk({tbl[i].name, "_flags"}, 64'(fl), 64'(tbl[i].fl));
         chk({tbl[i].name, "_latency"}, 64'(lat), 64'd58);
         chk({tbl[i].name, "_shape"}, 64'(shp), 64'd1);
      end

      repeat (5) @(negedge clock);
      chk("hold_result", result, tbl[NVEC-1].exp);
      chk("hold_flags", 64'({nv, dz, of}), 64'(tbl[NVEC-1].fl));

      // en pulsed mid-operation must be ignored
      do_op(3'd0, 64'h4018000000000000, 64'h4000000000000000, 10, r, fl, lat, shp);
      chk("busy_en_res", r, 64'h4008000000000000);
      chk("busy_en_latency", 64'(lat), 64'd58);
      chk("busy_en_shape", 64'(shp), 64'd1);
      nvalid = 0;
      for (int k = 0; k < 70; k++) begin
         @(negedge clock);
         if (valid) nvalid++;
      end
      chk("busy_en_no_second_valid", 64'(nvalid), 64'd0);

      // Reset in the middle of DIV
      rm = 3'd0; src1 = 64'h3FF0000000000000; src2 = 64'h4008000000000000; en = 1'b1;
      @(negedge clock);
      en = 1'b0;
      repeat (19) @(negedge clock);
      reset = 1'b1;
      #1;
      chk("midreset_ctrl", {62'd0, busy, valid}, 64'd0);
      chk("midreset_result", result, 64'd0);
      chk("midreset_flags", 64'({nv, dz, of}), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      do_op(3'd1, 64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 0, r, fl, lat, shp);
      chk("after_reset_res", r, 64'h7FEFFFFFFFFFFFFF);
      chk("after_reset_flags", 64'(fl), 64'd1);
      chk("after_reset_latency", 64'(lat), 64'd58);
      chk("after_reset_shape", 64'(shp), 64'd1);

      // Random operands against the reference model
      for (int i = 0; i < 150; i++) begin
         m = 3'($urandom_range(0, 4));
         a = rnd_fp();
         b = rnd_fp();
         exp_r = ref_div(m, a, b);
         do_op(m, a, b, 0, r, fl, lat, shp);
         checks++;
         if (r !== exp_r.res || fl !== exp_r.fl || lat != 58) begin
            failures++;
            $display("FAIL rand rm=%0d a=%h b=%h: got %h flags %b lat %0d expected %h flags %b lat 58",
                     m, a, b, r, fl, lat, exp_r.res, exp_r.fl);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
